// File: rtl/ball_motion_square.sv
// ============================================================================
//  Module      : ball_motion_square
//  Description : Per-ball motion and bounding-box stage feeding the ball
//                bitmap ROM. Integrates fixed-point bouncing-ball physics once
//                per frame, runs an IDLE/MOVING/POPPING life cycle and maps the
//                VGA pixel coordinate into box offsets one clock later.
//                Optional build macro: BALL_CEILING_BOUNCE_EN (ceiling clamp).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_motion_square #(
    parameter int FRAC_BITS   = 6,
    parameter int OBJECT_SIZE = 40,
    parameter int INIT_X      = 100,
    parameter int INIT_Y      = 100,
    parameter int INIT_VX     = 64,
    parameter int BOUNCE_VY   = 512,
    parameter int GRAVITY     = 16,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_TOP       = 0,
    parameter int Y_FLOOR     = 440,
    parameter int POP_FRAMES  = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        launch,
    input  logic        hit,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        visible,
    output logic        popped,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY
);

    // Position/velocity width: 11 integer bits, fraction, plus sign.
    localparam int W = 12 + FRAC_BITS;

    localparam logic signed [W-1:0] c_init_x    = W'(INIT_X * (2 ** FRAC_BITS));
    localparam logic signed [W-1:0] c_init_y    = W'(INIT_Y * (2 ** FRAC_BITS));
    localparam logic signed [W-1:0] c_init_vx   = W'(INIT_VX);
    localparam logic signed [W-1:0] c_gravity   = W'(GRAVITY);
    localparam logic signed [W-1:0] c_bounce_vy = W'(-BOUNCE_VY);
    localparam logic signed [W-1:0] c_zero      = '0;
    localparam logic signed [W-1:0] c_floor_px  = W'(Y_FLOOR - OBJECT_SIZE);
    localparam logic signed [W-1:0] c_floor_y   = W'((Y_FLOOR - OBJECT_SIZE) * (2 ** FRAC_BITS));
    localparam logic signed [W-1:0] c_left_px   = W'(X_MIN);
    localparam logic signed [W-1:0] c_left_x    = W'(X_MIN * (2 ** FRAC_BITS));
    localparam logic signed [W-1:0] c_right_px  = W'(X_MAX - OBJECT_SIZE + 1);
    localparam logic signed [W-1:0] c_right_x   = W'((X_MAX - OBJECT_SIZE + 1) * (2 ** FRAC_BITS));
    localparam logic signed [W-1:0] c_ceil_px   = W'(Y_TOP);
    localparam logic signed [W-1:0] c_ceil_y    = W'(Y_TOP * (2 ** FRAC_BITS));
    localparam logic signed [11:0]  c_size      = 12'(OBJECT_SIZE);
    localparam logic [7:0]          c_pop_last  = 8'(POP_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MOVING  = 2'd1,
        S_POPPING = 2'd2
    } state_t;

    state_t r_state, w_state_next;
    logic [7:0] r_pop_cnt, w_pop_cnt_next;
    logic       w_pop_done;

    logic signed [W-1:0] r_x, r_y, r_vx, r_vy;
    logic signed [W-1:0] w_vy_new, w_y_new, w_x_new, w_x_px, w_y_px;
    logic signed [W-1:0] w_x_nx, w_y_nx, w_vx_nx, w_vy_nx;

    logic signed [11:0] w_px, w_py, w_tlx, w_tly;
    logic               w_inside;

    assign topLeftX = r_x[FRAC_BITS+10:FRAC_BITS];
    assign topLeftY = r_y[FRAC_BITS+10:FRAC_BITS];

    // Life-cycle state register.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state   <= S_IDLE;
            r_pop_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pop_cnt <= w_pop_cnt_next;
        end
    end

    // Next-state logic; launch wins in IDLE, hit wins in MOVING.
    always_comb begin
        w_state_next   = r_state;
        w_pop_cnt_next = r_pop_cnt;
        w_pop_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (launch) w_state_next = S_MOVING;
            end
            S_MOVING: begin
                if (hit) begin
                    w_state_next   = S_POPPING;
                    w_pop_cnt_next = '0;
                end
            end
            S_POPPING: begin
                if (startOfFrame) begin
                    if (r_pop_cnt == c_pop_last) begin
                        w_state_next = S_IDLE;
                        w_pop_done   = 1'b1;
                    end else begin
                        w_pop_cnt_next = r_pop_cnt + 8'd1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One-frame physics step with floor, wall and optional ceiling clamps.
    always_comb begin
        w_vy_new = r_vy + c_gravity;
        w_y_new  = r_y + w_vy_new;
        w_x_new  = r_x + r_vx;
        w_x_px   = w_x_new >>> FRAC_BITS;
        w_y_px   = w_y_new >>> FRAC_BITS;
        w_x_nx   = w_x_new;
        w_y_nx   = w_y_new;
        w_vx_nx  = r_vx;
        w_vy_nx  = w_vy_new;
        if (w_y_px >= c_floor_px && w_vy_new > c_zero) begin
            w_y_nx  = c_floor_y;
            w_vy_nx = c_bounce_vy;
        end
`ifdef BALL_CEILING_BOUNCE_EN
        if (w_y_px < c_ceil_px && w_vy_new < c_zero) begin
            w_y_nx  = c_ceil_y;
            w_vy_nx = c_zero;
        end
`endif
        if (w_x_px <= c_left_px && r_vx < c_zero) begin
            w_x_nx  = c_left_x;
            w_vx_nx = -r_vx;
        end else if (w_x_px >= c_right_px && r_vx > c_zero) begin
            w_x_nx  = c_right_x;
            w_vx_nx = -r_vx;
        end
    end

`ifndef BALL_CEILING_BOUNCE_EN
    // Ceiling constants exist only for the ceiling-bounce build.
    logic w_unused_ceiling;
    assign w_unused_ceiling = (c_ceil_px == c_ceil_y);
`endif

    // Position/velocity registers: reload on launch, integrate per frame.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_x  <= c_init_x;
            r_y  <= c_init_y;
            r_vx <= c_init_vx;
            r_vy <= c_zero;
        end else if (r_state == S_IDLE && launch) begin
            r_x  <= c_init_x;
            r_y  <= c_init_y;
            r_vx <= c_init_vx;
            r_vy <= c_zero;
        end else if (r_state == S_MOVING && startOfFrame) begin
            r_x  <= w_x_nx;
            r_y  <= w_y_nx;
            r_vx <= w_vx_nx;
            r_vy <= w_vy_nx;
        end
    end

    // Signed 12-bit compare keeps a box partly above/left of 0 correct.
    always_comb begin
        w_px     = {1'b0, pixelX};
        w_py     = {1'b0, pixelY};
        w_tlx    = {topLeftX[10], topLeftX};
        w_tly    = {topLeftY[10], topLeftY};
        w_inside = (w_px >= w_tlx) && (w_px < w_tlx + c_size) &&
                   (w_py >= w_tly) && (w_py < w_tly + c_size);
    end

    // Registered pixel-path and status outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            offsetX         <= '0;
            offsetY         <= '0;
            InsideRectangle <= 1'b0;
            visible         <= 1'b0;
            popped          <= 1'b0;
        end else begin
            InsideRectangle <= w_inside;
            offsetX         <= w_inside ? (pixelX - topLeftX) : 11'd0;
            offsetY         <= w_inside ? (pixelY - topLeftY) : 11'd0;
            visible         <= (r_state == S_MOVING);
            popped          <= w_pop_done;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ball_motion_square.sv
// ============================================================================
//  Module      : tb_ball_motion_square
//  Description : Self-checking bench for ball_motion_square. Four instances
//                share stimulus: 0 default, 1 INIT_Y=400 (floor), 2 INIT_X=599
//                (right wall), 3 INIT_Y=400/BOUNCE_VY=4000 (ceiling).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_motion_square;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame, launch, hit;
    logic [10:0] pixelX, pixelY;

    logic [10:0] offX [4];
    logic [10:0] offY [4];
    logic [10:0] tlX  [4];
    logic [10:0] tlY  [4];
    logic        ins  [4];
    logic        vis  [4];
    logic        pop  [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        ball_motion_square #(
            .INIT_X   ((i == 2) ? 599 : 100),
            .INIT_Y   ((i == 1 || i == 3) ? 400 : 100),
            .BOUNCE_VY((i == 3) ? 4000 : 512)
        ) u_dut (
            .clk            (clk),
            .resetN         (resetN),
            .startOfFrame   (startOfFrame),
            .pixelX         (pixelX),
            .pixelY         (pixelY),
            .launch         (launch),
            .hit            (hit),
            .offsetX        (offX[i]),
            .offsetY        (offY[i]),
            .InsideRectangle(ins[i]),
            .visible        (vis[i]),
            .popped         (pop[i]),
            .topLeftX       (tlX[i]),
            .topLeftY       (tlY[i])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive inputs away from the active edge, then sample 1 ns after it.
    task automatic step(input logic l, input logic h, input logic s,
                        input logic [10:0] px, input logic [10:0] py);
        @(negedge clk);
        launch = l; hit = h; startOfFrame = s; pixelX = px; pixelY = py;
        @(posedge clk);
        #1;
        launch = 1'b0; hit = 1'b0; startOfFrame = 1'b0;
    endtask

    typedef struct {
        logic        l, h, s;
        logic [10:0] px, py;
        logic [10:0] tlx, tly;
        logic        vis, ins;
        logic [10:0] ox, oy;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // inputs l,h,s,px,py  | expected tlX,tlY,vis,ins,offX,offY (instance 0)
        vecs[0] = '{1'b0, 1'b1, 1'b0, 11'd100, 11'd100, 11'd100, 11'd100, 1'b0, 1'b1, 11'd0,  11'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 11'd139, 11'd139, 11'd100, 11'd100, 1'b0, 1'b1, 11'd39, 11'd39};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 11'd140, 11'd100, 11'd100, 11'd100, 1'b1, 1'b0, 11'd0,  11'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 11'd99,  11'd100, 11'd101, 11'd100, 1'b1, 1'b0, 11'd0,  11'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 11'd101, 11'd100, 11'd101, 11'd100, 1'b1, 1'b1, 11'd0,  11'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 11'd141, 11'd100, 11'd101, 11'd100, 1'b1, 1'b0, 11'd0,  11'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 11'd140, 11'd139, 11'd101, 11'd100, 1'b1, 1'b1, 11'd39, 11'd39};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 11'd140, 11'd140, 11'd101, 11'd100, 1'b1, 1'b0, 11'd0,  11'd0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 11'd0,   11'd0,   11'd102, 11'd100, 1'b1, 1'b0, 11'd0,  11'd0};

        resetN = 1'b0; launch = 1'b0; hit = 1'b0; startOfFrame = 1'b0;
        pixelX = 11'd110; pixelY = 11'd110;

        // Reset: three clocks low with the pixel inside the box.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ins",  int'(ins[0]),  0);
        chk("rst_offx", int'(offX[0]), 0);
        chk("rst_vis",  int'(vis[0]),  0);
        chk("rst_pop",  int'(pop[0]),  0);
        chk("rst_tlx",  int'(tlX[0]),  100);
        chk("rst_tly",  int'(tlY[0]),  100);
        @(negedge clk);
        resetN = 1'b1;

        // Main table: hit ignored in IDLE, launch, two frames, box edges.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].l, vecs[i].h, vecs[i].s, vecs[i].px, vecs[i].py);
            chk($sformatf("v%0d_tlx", i),  int'(tlX[0]),  int'(vecs[i].tlx));
            chk($sformatf("v%0d_tly", i),  int'(tlY[0]),  int'(vecs[i].tly));
            chk($sformatf("v%0d_vis", i),  int'(vis[0]),  int'(vecs[i].vis));
            chk($sformatf("v%0d_ins", i),  int'(ins[0]),  int'(vecs[i].ins));
            chk($sformatf("v%0d_offx", i), int'(offX[0]), int'(vecs[i].ox));
            chk($sformatf("v%0d_offy", i), int'(offY[0]), int'(vecs[i].oy));
            if (i == 3) begin
                chk("frame1_vy",    g_dut[0].u_dut.r_vy, 16);
                chk("floor_tly",    int'(tlY[1]), 400);
                chk("floor_vy",     g_dut[1].u_dut.r_vy, -512);
                chk("rwall_tlx",    int'(tlX[2]), 600);
                chk("rwall_vx",     g_dut[2].u_dut.r_vx, -64);
            end
        end
        chk("floor2_vy",  g_dut[1].u_dut.r_vy, -496);
        chk("floor2_tly", int'(tlY[1]), 392);
        chk("rwall2_tlx", int'(tlX[2]), 599);
        chk("ceil_f2_tly", int'(tlY[3]), 337);

        // Instance 3 rises past the ceiling on its eighth frame.
        for (int f = 0; f < 5; f++) step(1'b0, 1'b0, 1'b1, 11'd0, 11'd0);
        chk("ceil_f7_tly", int'(tlY[3]), 30);
        step(1'b0, 1'b0, 1'b1, 11'd0, 11'd0);
`ifdef BALL_CEILING_BOUNCE_EN
        chk("ceil_tly", int'(tlY[3]), 0);
        chk("ceil_vy",  g_dut[3].u_dut.r_vy, 0);
`else
        chk("ceil_tly", int'(tlY[3]), 2017);
        chk("ceil_vy",  g_dut[3].u_dut.r_vy, -3888);
`endif

        // Pop: hit while MOVING; visible drops, position freezes.
        begin
            logic [10:0] fx, fy;
            step(1'b0, 1'b1, 1'b0, 11'd0, 11'd0);
            fx = tlX[0]; fy = tlY[0];
            step(1'b1, 1'b0, 1'b0, 11'd0, 11'd0);
            chk("pop_vis", int'(vis[0]), 0);
            for (int f = 1; f <= 8; f++) begin
                step(1'b0, 1'b0, 1'b1, 11'd0, 11'd0);
                chk($sformatf("pop_f%0d", f), int'(pop[0]), (f == 8) ? 1 : 0);
            end
            chk("pop_frz_x", int'(tlX[0]), int'(fx));
            chk("pop_frz_y", int'(tlY[0]), int'(fy));
            step(1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
            chk("pop_pulse_end", int'(pop[0]), 0);
        end

        // Launch and hit together in IDLE: launch wins.
        step(1'b1, 1'b1, 1'b0, 11'd0, 11'd0);
        step(1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
        chk("lh_vis", int'(vis[0]), 1);
        chk("lh_tlx", int'(tlX[0]), 100);
        step(1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
        chk("lh_still_moving", int'(vis[0]), 1);

        // Mid-operation reset aborts MOVING.
        step(1'b0, 1'b0, 1'b1, 11'd0, 11'd0);
        @(negedge clk);
        resetN = 1'b0; pixelX = 11'd110; pixelY = 11'd110;
        @(posedge clk);
        #1;
        chk("mrst_vis", int'(vis[0]), 0);
        chk("mrst_ins", int'(ins[0]), 0);
        chk("mrst_tlx", int'(tlX[0]), 100);
        chk("mrst_vy",  g_dut[0].u_dut.r_vy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
